// File: rtl/seq_pix_pkg.sv
// Shared definitions for the PIX_V1_SW_28_10_19 timing sequencer.
//   - seq_state_t : sequencer state encoding (IDLE, MEASURE, FINISH)
//   - TIME_WIDTH_DEF / SEL_WIDTH_DEF : default widths
//   - RESET_N_RST / AOUT_RESET_RST : idle (reset) levels of the two pixel resets
package seq_pix_pkg;

  localparam int TIME_WIDTH_DEF = 10;
  localparam int SEL_WIDTH_DEF  = 4;

  // _RESET is active-low, AOUT_RESET active-high: both asserted while idle.
  localparam logic RESET_N_RST    = 1'b0;
  localparam logic AOUT_RESET_RST = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_FINISH  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/seq_rise_detect.sv
// Registered rising-edge detector.
// Ports:
//   clk   in  system clock
//   reset in  asynchronous active-low reset
//   din   in  level to watch
//   rise  out 1 when din is high and was low on the previous clock
module seq_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic din_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) din_d <= 1'b0;
    else        din_d <= din;
  end

  assign rise = din & ~din_d;

endmodule

// File: rtl/sequencer_for_pix_v1_sw_28_10_19.sv
// One-shot timing sequencer for the PIX_V1_SW_28_10_19 pixel test structure.
// A rising edge on run_sequencer (accepted only when idle) latches the static
// configuration and starts a measurement run of max(measure_time,1) cycles,
// releasing _RESET and AOUT_RESET at their programmed offsets, followed by a
// single FINISH cycle.
//
// Optional feature: define SEQUENCER_RUN_COUNT_EN to add run_count[15:0],
// a wrapping count of completed runs.
//
// Ports:
//   clk, reset (async active-low)
//   run_sequencer                  start request (rising edge)
//   RESET_release_time, AOUT_RESET_release_time, measure_time : cycle offsets
//   SEL_input, BLOCK_RESET_input, BLOCK_HOLD_input, POLARITY_input : config
//   ready_flag, measure_flag       status
//   SEL, ENA, BLOCK_RESET, _RESET, AOUT_RESET, BLOCK_HOLD, POLARITY : pins
//
// state   | meaning
// IDLE    | ready for a start, pins in reset levels
// MEASURE | run in progress, counter t = cycle index within the run
// FINISH  | one-cycle wrap-up, pins back to reset levels
module sequencer_for_pix_v1_sw_28_10_19
  import seq_pix_pkg::*;
#(
  parameter int TIME_WIDTH = TIME_WIDTH_DEF,
  parameter int SEL_WIDTH  = SEL_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run_sequencer,
  input  logic [TIME_WIDTH-1:0] RESET_release_time,
  input  logic [TIME_WIDTH-1:0] AOUT_RESET_release_time,
  input  logic [TIME_WIDTH-1:0] measure_time,
  input  logic [SEL_WIDTH-1:0]  SEL_input,
  input  logic                  BLOCK_RESET_input,
  input  logic                  BLOCK_HOLD_input,
  input  logic                  POLARITY_input,
  output logic                  ready_flag,
  output logic                  measure_flag,
  output logic [SEL_WIDTH-1:0]  SEL,
  output logic                  ENA,
  output logic                  BLOCK_RESET,
  output logic                  _RESET,
  output logic                  AOUT_RESET,
  output logic                  BLOCK_HOLD,
`ifdef SEQUENCER_RUN_COUNT_EN
  output logic                  POLARITY,
  output logic [15:0]           run_count
`else
  output logic                  POLARITY
`endif
);

  localparam logic [TIME_WIDTH-1:0] T_ONE = TIME_WIDTH'(1);

  seq_state_t            state;
  logic [TIME_WIDTH-1:0] t;
  logic [TIME_WIDTH-1:0] last_t;
  logic [TIME_WIDTH-1:0] next_t;
  logic                  rise;

  seq_rise_detect u_rise (
    .clk   (clk),
    .reset (reset),
    .din   (run_sequencer),
    .rise  (rise)
  );

  // measure_time = 0 behaves as a 1-cycle run.
  assign last_t = (measure_time == '0) ? '0 : measure_time - T_ONE;
  assign next_t = t + T_ONE;

  // Pin levels are computed one cycle ahead (for next_t) so the registered
  // outputs line up with the counter value of the cycle they appear in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      t            <= '0;
      ready_flag   <= 1'b1;
      measure_flag <= 1'b0;
      ENA          <= 1'b0;
      _RESET       <= RESET_N_RST;
      AOUT_RESET   <= AOUT_RESET_RST;
      SEL          <= '0;
      BLOCK_RESET  <= 1'b0;
      BLOCK_HOLD   <= 1'b0;
      POLARITY     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ready_flag <= 1'b1;
          if (rise) begin
            state        <= ST_MEASURE;
            t            <= '0;
            SEL          <= SEL_input;
            BLOCK_RESET  <= BLOCK_RESET_input;
            BLOCK_HOLD   <= BLOCK_HOLD_input;
            POLARITY     <= POLARITY_input;
            ready_flag   <= 1'b0;
            ENA          <= 1'b1;
            measure_flag <= 1'b1;
            _RESET       <= (RESET_release_time == '0);
            AOUT_RESET   <= (AOUT_RESET_release_time != '0);
          end
        end
        ST_MEASURE: begin
          if (t == last_t) begin
            state        <= ST_FINISH;
            ENA          <= 1'b0;
            measure_flag <= 1'b0;
            _RESET       <= RESET_N_RST;
            AOUT_RESET   <= AOUT_RESET_RST;
          end else begin
            t          <= next_t;
            _RESET     <= (next_t >= RESET_release_time);
            AOUT_RESET <= (next_t < AOUT_RESET_release_time);
          end
        end
        ST_FINISH: begin
          state      <= ST_IDLE;
          ready_flag <= 1'b1;
        end
        default: begin
          state      <= ST_IDLE;
          ready_flag <= 1'b1;
        end
      endcase
    end
  end

`ifdef SEQUENCER_RUN_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  run_count <= '0;
    else if (state == ST_FINISH) run_count <= run_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_sequencer_for_pix_v1_sw_28_10_19.sv
// Self-checking bench for sequencer_for_pix_v1_sw_28_10_19. Expected pin
// levels are derived from the run index k (cycles since the start edge) and
// the run length L = max(measure_time,1).
module tb_sequencer_for_pix_v1_sw_28_10_19;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run_sequencer = 1'b0;
  logic [9:0] RESET_release_time = '0;
  logic [9:0] AOUT_RESET_release_time = '0;
  logic [9:0] measure_time = '0;
  logic [3:0] SEL_input = '0;
  logic       BLOCK_RESET_input = 1'b0;
  logic       BLOCK_HOLD_input = 1'b0;
  logic       POLARITY_input = 1'b0;
  logic       ready_flag, measure_flag, ENA, BLOCK_RESET, x_reset;
  logic       AOUT_RESET, BLOCK_HOLD, POLARITY;
  logic [3:0] SEL;
`ifdef SEQUENCER_RUN_COUNT_EN
  logic [15:0] run_count;
`endif

  int checks = 0;
  int failures = 0;
  int exp_runs = 0;

  always #5 clk = ~clk;

  sequencer_for_pix_v1_sw_28_10_19 dut (
    .clk                     (clk),
    .reset                   (reset),
    .run_sequencer           (run_sequencer),
    .RESET_release_time      (RESET_release_time),
    .AOUT_RESET_release_time (AOUT_RESET_release_time),
    .measure_time            (measure_time),
    .SEL_input               (SEL_input),
    .BLOCK_RESET_input       (BLOCK_RESET_input),
    .BLOCK_HOLD_input        (BLOCK_HOLD_input),
    .POLARITY_input          (POLARITY_input),
    .ready_flag              (ready_flag),
    .measure_flag            (measure_flag),
    .SEL                     (SEL),
    .ENA                     (ENA),
    .BLOCK_RESET             (BLOCK_RESET),
    ._RESET                  (x_reset),
    .AOUT_RESET              (AOUT_RESET),
    .BLOCK_HOLD              (BLOCK_HOLD),
`ifdef SEQUENCER_RUN_COUNT_EN
    .POLARITY                (POLARITY),
    .run_count               (run_count)
`else
    .POLARITY                (POLARITY)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, ready_flag, 1);
    chk({tag, "_ena"}, ENA, 0);
    chk({tag, "_meas"}, measure_flag, 0);
    chk({tag, "_rstn"}, x_reset, 0);
    chk({tag, "_aout"}, AOUT_RESET, 1);
    chk({tag, "_cfg"}, {SEL, BLOCK_RESET, BLOCK_HOLD, POLARITY}, 0);
  endtask

  // One run: hold = cycles run_sequencer stays high (incl. start edge),
  // pulse_k = run index of an extra 1-cycle pulse (-1 none),
  // abort_k = run index at which async reset is asserted (-1 none).
  task automatic do_run(input logic [3:0] sel, input logic br, input logic bh,
                        input logic pol, input int rel, input int arel,
                        input int mt, input int hold, input int pulse_k,
                        input int abort_k);
    int len, kmax;
    logic in_run;
    len  = (mt == 0) ? 1 : mt;
    kmax = ((len + 1 > hold) ? len + 1 : hold) + 2;
    SEL_input = sel; BLOCK_RESET_input = br; BLOCK_HOLD_input = bh;
    POLARITY_input = pol;
    RESET_release_time = 10'(rel);
    AOUT_RESET_release_time = 10'(arel);
    measure_time = 10'(mt);
    chk("pre_ready", ready_flag, 1);
    run_sequencer = 1'b1;
    tick();
    for (int k = 0; k <= kmax; k++) begin
      run_sequencer = (k < hold - 1) || (k == pulse_k);
      if (k == abort_k) begin
        #2 reset = 1'b0;
        #1 chk_reset_vals("abort");
        run_sequencer = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        chk_reset_vals("post_abort");
        return;
      end
      in_run = (k < len);
      chk($sformatf("ena_k%0d", k), ENA, in_run);
      chk($sformatf("meas_k%0d", k), measure_flag, in_run);
      chk($sformatf("ready_k%0d", k), ready_flag, k > len);
      chk($sformatf("rstn_k%0d", k), x_reset, in_run && (k >= rel));
      chk($sformatf("aout_k%0d", k), AOUT_RESET, !(in_run && (k >= arel)));
      chk($sformatf("cfg_k%0d", k), {SEL, BLOCK_RESET, BLOCK_HOLD, POLARITY},
          {sel, br, bh, pol});
`ifdef SEQUENCER_RUN_COUNT_EN
      chk($sformatf("cnt_k%0d", k), run_count, 32'(exp_runs + ((k > len) ? 1 : 0)));
`endif
      tick();
    end
    exp_runs++;
    run_sequencer = 1'b0;
    tick();
  endtask

  initial begin
    // reset held low for two cycles
    tick(); tick();
    chk_reset_vals("rst");
    reset = 1'b1;
    tick();
    chk_reset_vals("rst_rel");

    // directed 1-cycle pulse run
    do_run(4'd3, 1'b1, 1'b0, 1'b1, 5, 7, 33, 1, -1, -1);

    repeat (1000) tick();
    chk("idle_ready", ready_flag, 1);

    // level held 50 cycles: one run, no retrigger
    do_run(4'd9, 1'b0, 1'b1, 1'b0, 5, 7, 33, 50, -1, -1);
    // second pulse inside MEASURE is ignored
    do_run(4'd6, 1'b1, 1'b1, 1'b1, 5, 7, 33, 1, 12, -1);
    // measure_time = 0 -> single-cycle MEASURE
    do_run(4'd1, 1'b0, 1'b0, 1'b1, 0, 1, 0, 1, -1, -1);
    // release after end of run -> _RESET never released
    do_run(4'd2, 1'b1, 1'b0, 1'b0, 40, 50, 33, 1, -1, -1);
    // async abort at t=10, then a normal run
    do_run(4'd5, 1'b1, 1'b1, 1'b0, 5, 7, 33, 1, -1, 10);
    do_run(4'd4, 1'b0, 1'b1, 1'b1, 3, 9, 20, 1, -1, -1);

    // randomized runs
    for (int r = 0; r < 8; r++) begin
      do_run(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 45)), int'($urandom_range(0, 45)),
             int'($urandom_range(0, 40)), int'($urandom_range(1, 3)), -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sequencer_for_pix_v1_sw_28_10_19.md
Name: sequencer_for_pix_v1_sw_28_10_19

Overview:
- One-shot timing sequencer that drives the control pins of the PIX_V1_SW_28_10_19 pixel test structure.
- On a start request it latches the static configuration (SEL, BLOCK_RESET, BLOCK_HOLD, POLARITY).
- It releases the pixel reset (_RESET) and the analog-output reset (AOUT_RESET) at programmable times, then flags a measurement window.
- It sits between the host/register interface and the test-structure pins of the FPGA test setup.

Parameters:
- TIME_WIDTH, 10, width of all time/counter values (units: clk cycles).
- SEL_WIDTH, 4, width of the SEL channel select.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- run_sequencer  in  1  start request; rising-edge triggered.
- RESET_release_time  in  TIME_WIDTH  cycle offset at which _RESET is released.
- AOUT_RESET_release_time  in  TIME_WIDTH  cycle offset at which AOUT_RESET is released.
- measure_time  in  TIME_WIDTH  run length in cycles.
- SEL_input  in  SEL_WIDTH  value latched to SEL at start.
- BLOCK_RESET_input  in  1  value latched to BLOCK_RESET at start.
- BLOCK_HOLD_input  in  1  value latched to BLOCK_HOLD at start.
- POLARITY_input  in  1  value latched to POLARITY at start.
- ready_flag  out  1  1 = idle, a new run is accepted.
- measure_flag  out  1  1 during the measure state.
- SEL  out  SEL_WIDTH  pixel select.
- ENA  out  1  structure enable, high during a run.
- BLOCK_RESET  out  1  latched config.
- _RESET  out  1  active-low pixel reset.
- AOUT_RESET  out  1  active-high analog-output reset.
- BLOCK_HOLD  out  1  latched config.
- POLARITY  out  1  latched config.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, counter 0, ready_flag=1, measure_flag=0, ENA=0, _RESET=0, AOUT_RESET=1, SEL=0, BLOCK_RESET=0, BLOCK_HOLD=0, POLARITY=0, edge register=0.
- Start detection: the design registers run_sequencer as run_d. A start occurs when run_sequencer=1 and run_d=0 and the state is IDLE.
- A level held high triggers exactly one run.
- Edges arriving outside IDLE are ignored, not queued.
- States and transitions:
  - IDLE: ready_flag=1. On start → MEASURE. On that same edge: latch the four *_input values into their outputs, set counter=0, ready_flag=0, ENA=1, measure_flag=1.
  - MEASURE: counter t increments each cycle; t=0 is the first cycle in MEASURE.
    - _RESET = 0 while t < RESET_release_time, else 1.
    - AOUT_RESET = 1 while t < AOUT_RESET_release_time, else 0.
    - The state is left when t = measure_time-1 (treat measure_time=0 as 1), so MEASURE lasts max(measure_time,1) cycles → FINISH.
  - FINISH: one cycle. ENA=0, measure_flag=0, _RESET=0, AOUT_RESET=1, ready_flag=0 → IDLE.
  - Back in IDLE: ready_flag=1 and a new start is accepted.
- Timing inputs are sampled every cycle during MEASURE; the host holds them stable during a run.
- A release time ≥ measure_time means that reset is never released during the run.
- Configuration outputs (SEL, BLOCK_*, POLARITY) hold their latched values until the next start.
- Counter width is TIME_WIDTH and it never wraps: the maximum run is 2^TIME_WIDTH-1 cycles.
- Asynchronous reset mid-run: immediately returns to reset values; no FINISH cycle.

Optional Feature:
- Macro: SEQUENCER_RUN_COUNT_EN.
- When defined: adds output run_count [15:0], reset to 0. It increments on each FINISH cycle and wraps at 0xFFFF→0.
- When undefined: no run_count port and no counter logic.

Decomposition:
- Shared package seq_pix_pkg: state enum (IDLE, MEASURE, FINISH), TIME_WIDTH/SEL_WIDTH defaults, reset-value constants for _RESET/AOUT_RESET.
- One natural sub-module: seq_rise_detect (registered rising-edge detector on run_sequencer, async active-low reset).

Test Plan:
- Reset held low 2 cycles → ready_flag=1, ENA=0, _RESET=0, AOUT_RESET=1, SEL=0, measure_flag=0.
- SEL_input=3, RESET_release_time=5, AOUT_RESET_release_time=7, measure_time=33, 1-cycle run_sequencer pulse → next cycle SEL=3, ENA=1, measure_flag=1, ready_flag=0. _RESET low for t=0..4 and high for t=5..32. AOUT_RESET high for t=0..6 and low for t=7..32. FINISH at t=33, ready_flag=1 one cycle later.
- After 1000 idle cycles, run_sequencer held high 50 cycles → exactly one 33-cycle run; no retrigger after FINISH while the input is still high.
- Second pulse during MEASURE → ignored; run length unchanged at 33.
- measure_time=0 → MEASURE lasts 1 cycle. RESET_release_time=40 with measure_time=33 → _RESET stays 0 for the whole run.
- Reset asserted at t=10 of a run → outputs return to reset values asynchronously; a new start after release runs normally. With SEQUENCER_RUN_COUNT_EN defined, run_count increments by 1 per completed run and not for the aborted one.
